// File: rtl/times_ctrl_pkg.sv
// Shared types and helpers for the AXI-Lite multiplication-table controller.
package times_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT_WR = 3'd0,
    INIT_B  = 3'd1,
    IDLE    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam int         TABLE_DEPTH = 64;

  // Table entry {a,b} lives at byte address {a, b, 2'b00}.
  function automatic logic [7:0] build_addr(input logic [2:0] a, input logic [2:0] b);
    return {a, b, 2'b00};
  endfunction

  function automatic logic [5:0] times6(input logic [2:0] x, input logic [2:0] y);
    return {3'b000, x} * {3'b000, y};
  endfunction

endpackage

// File: rtl/axi_lite_wr_chan.sv
// Tracks the AW and W handshakes of one write independently; done fires when both have completed.
module axi_lite_wr_chan (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  assign awvalid = active && !aw_done_q;
  assign wvalid  = active && !w_done_q;
  // Same-cycle completion of the last outstanding channel counts as done.
  assign done    = active && (aw_done_q || awready) && (w_done_q || wready);

  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (done) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (awvalid && awready) aw_done_d = 1'b1;
      if (wvalid && wready)   w_done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/axi_lite_times_ctrl.sv
// 3x3-bit multiplier served from a 64-entry table over AXI-Lite.
// Define TIMES_INIT_EN to load the table through the write channel after reset.
module axi_lite_times_ctrl
  import times_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        a,
  input  logic [2:0]        b,
  input  logic              req,
  output logic              ready,
  output logic [5:0]        result,
  output logic              valid,
  output logic              init_done,
  output logic              err,
  output logic              m_axi_aresetn,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  // Handshake rule on every channel: a valid, once raised, stays high with
  // stable payload until the cycle its ready is sampled high at a clock edge.

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [5:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       wr_done;
  logic       unused_sigs;

  assign m_axi_aresetn = ~rst;
  // Valid/ready outputs are gated by rst so they drop in the reset cycle itself.
  assign ready         = (state_q == IDLE) && !rst;
  assign m_axi_arvalid = (state_q == RD_AR) && !rst;
  assign m_axi_rready  = (state_q == RD_R) && !rst;
  assign m_axi_araddr  = {{(ADDR_W-8){1'b0}}, build_addr(a_q, b_q)};
  assign result        = result_q;
  assign valid         = valid_q;
  assign err           = err_q;

`ifdef TIMES_INIT_EN
  logic init_done_q, init_done_d;
  logic wr_active;

  assign wr_active = (state_q == INIT_WR) && !rst;

  axi_lite_wr_chan u_wr_chan (
    .clk     (clk),
    .rst     (rst),
    .active  (wr_active),
    .awready (m_axi_awready),
    .wready  (m_axi_wready),
    .awvalid (m_axi_awvalid),
    .wvalid  (m_axi_wvalid),
    .done    (wr_done)
  );

  assign m_axi_bready = (state_q == INIT_B) && !rst;
  assign m_axi_awaddr = {{(ADDR_W-8){1'b0}}, build_addr(idx_q[5:3], idx_q[2:0])};
  assign m_axi_wdata  = {{(DATA_W-6){1'b0}}, times6(idx_q[5:3], idx_q[2:0])};
  assign m_axi_wstrb  = 4'hF;
  assign init_done    = init_done_q;
  assign unused_sigs  = ^{m_axi_rdata[DATA_W-1:6]};

  always_comb begin
    init_done_d = init_done_q;
    if ((state_q == INIT_B) && m_axi_bvalid && (idx_q == 6'(TABLE_DEPTH-1)))
      init_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) init_done_q <= 1'b0;
    else     init_done_q <= init_done_d;
  end
`else
  assign wr_done       = 1'b0;
  assign m_axi_awvalid = 1'b0;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_bready  = 1'b0;
  assign m_axi_awaddr  = '0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = 4'h0;
  assign init_done     = 1'b1;
  assign unused_sigs   = ^{m_axi_rdata[DATA_W-1:6], m_axi_awready, m_axi_wready,
                           m_axi_bresp, m_axi_bvalid, idx_q, wr_done};
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
`ifdef TIMES_INIT_EN
      INIT_WR: if (wr_done) state_d = INIT_B;
      INIT_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_OKAY) err_d = 1'b1;
          if (idx_q == 6'(TABLE_DEPTH-1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = INIT_WR;
          end
        end
      end
`endif
      IDLE: begin
        if (req) begin
          a_d     = a;
          b_d     = b;
          state_d = RD_AR;
        end
      end
      RD_AR: if (m_axi_arready) state_d = RD_R;
      RD_R: begin
        if (m_axi_rvalid) begin
          // The data is delivered even when the slave flags an error.
          result_d = m_axi_rdata[5:0];
          valid_d  = 1'b1;
          if (m_axi_rresp != AXI_OKAY) err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef TIMES_INIT_EN
      state_q <= INIT_WR;
`else
      state_q <= IDLE;
`endif
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_times_ctrl.sv
// Directed bench for axi_lite_times_ctrl with a negedge-driven AXI-Lite slave model.
module tb_axi_lite_times_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  a = '0, b = '0;
  logic        req = 1'b0;
  logic        ready, valid, init_done, err;
  logic [5:0]  result;
  logic        m_axi_aresetn;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave configuration and bookkeeping.
  int          ar_wait = 0, r_delay = 0;
  logic [1:0]  rresp_v = 2'b00;
  bit          ar_fire, r_fire, aw_fire, w_fire, b_fire;
  bit          r_pend, aw_have, w_have;
  logic [31:0] ar_addr_s, aw_addr_s, w_data_s, wa_s, wd_s;
  logic [5:0]  rd_idx;
  int          ar_cnt, aw_cnt, w_cnt, r_wait, aw_w, w_w;
  int          wr_cnt, b_cnt, aw_hs_n, w_hs_n;
  int          drop_bad = 0, wr_act = 0;
  logic [31:0] mem [64];
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [31:0] exp_q[$];

  axi_lite_times_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .req(req), .ready(ready), .result(result),
    .valid(valid), .init_done(init_done), .err(err), .m_axi_aresetn(m_axi_aresetn),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400us");
    $fatal(1);
  end

  // Slave: handshakes from the previous cycle are retired, then new readies/valids are driven.
  always @(negedge clk) begin
    #1;
    if (!m_axi_aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
      ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
      r_pend = 0; aw_have = 0; w_have = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0;
      wr_cnt = 0; b_cnt = 0; aw_hs_n = 0; w_hs_n = 0;
      wr_addr_q.delete(); wr_data_q.delete();
    end else begin
      if (ar_fire) begin rd_idx = ar_addr_s[7:2]; r_wait = r_delay; r_pend = 1; ar_cnt = 0; end
      if (r_fire) begin m_axi_rvalid = 0; r_pend = 0; end
      if (b_fire) begin m_axi_bvalid = 0; b_cnt++; end
      if (aw_fire) begin aw_have = 1; wa_s = aw_addr_s; aw_hs_n++; aw_cnt = 0; end
      if (w_fire) begin w_have = 1; wd_s = w_data_s; w_hs_n++; w_cnt = 0; end
      if (aw_fire && m_axi_awvalid) drop_bad++;
      if (w_fire && m_axi_wvalid) drop_bad++;
      if (aw_have && w_have) begin
        mem[wa_s[7:2]] = wd_s;
        wr_addr_q.push_back(wa_s);
        wr_data_q.push_back(wd_s);
        wr_cnt++;
        aw_have = 0; w_have = 0;
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
      end
      m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_wait);
      if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
      if (r_pend && !m_axi_rvalid) begin
        if (r_wait == 0) begin
          m_axi_rvalid = 1; m_axi_rdata = mem[rd_idx]; m_axi_rresp = rresp_v;
        end else r_wait--;
      end
      // Write 5: AW accepted a cycle before W; write 6: the reverse.
      aw_w = (wr_cnt == 6) ? 1 : 0;
      w_w  = (wr_cnt == 5) ? 1 : 0;
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_w);
      if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
      m_axi_wready = m_axi_wvalid && (w_cnt >= w_w);
      if (m_axi_wvalid && !m_axi_wready) w_cnt++;
      ar_fire = m_axi_arvalid && m_axi_arready; ar_addr_s = m_axi_araddr;
      r_fire  = m_axi_rvalid && m_axi_rready;
      aw_fire = m_axi_awvalid && m_axi_awready; aw_addr_s = m_axi_awaddr;
      w_fire  = m_axi_wvalid && m_axi_wready; w_data_s = m_axi_wdata;
      b_fire  = m_axi_bvalid && m_axi_bready;
    end
  end

  always @(negedge clk) begin
    #2;
    if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) wr_act++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Driver: one lookup, observed for 16 cycles after the request cycle.
  task automatic do_lookup(input string tag, input logic [2:0] ia, input logic [2:0] ib,
                           input logic [31:0] exp_addr, input logic [5:0] exp_res,
                           input int exp_lat, input bit busy_req);
    int lat, pulses, ar_bad, busy_bad;
    bit ar_got;
    logic [31:0] ar_seen;
    logic [5:0]  res;
    lat = 0; pulses = 0; ar_bad = 0; busy_bad = 0; ar_got = 0; ar_seen = '1; res = '1;
    @(negedge clk);
    a = ia; b = ib; req = 1;
    exp_q.push_back(32'(exp_res));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      req = busy_req && (k <= 2);
      a = req ? ~ia : ia;
      b = req ? ~ib : ib;
      #2;
      if (valid) begin
        pulses++;
        if (pulses == 1) begin lat = k; res = result; end
      end
      if (pulses == 0 && ready) busy_bad++;
      if (m_axi_arvalid) begin
        if (!ar_got) begin ar_seen = m_axi_araddr; ar_got = 1; end
        else if (m_axi_araddr != ar_seen) ar_bad++;
      end
    end
    req = 0;
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_pulses"}, pulses, 1);
    check_eq({tag, "_result"}, 32'(res), exp_q.pop_front());
    check_eq({tag, "_araddr"}, ar_seen, exp_addr);
    check_eq({tag, "_ar_stable"}, ar_bad, 0);
    check_eq({tag, "_busy_ready"}, busy_bad, 0);
    check_eq({tag, "_hold"}, 32'(result), 32'(exp_res));
  endtask

  task automatic check_init(input string tag);
    bit ok;
    logic [31:0] ea, ed;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk); #2;
      if (init_done) ok = 1;
    end
    check_eq({tag, "_done"}, 32'(ok), 1);
    check_eq({tag, "_bresp_at_done"}, b_cnt, 64);
    check_eq({tag, "_aw_hs"}, aw_hs_n, 64);
    check_eq({tag, "_w_hs"}, w_hs_n, 64);
    check_eq({tag, "_valid_drop"}, drop_bad, 0);
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(32'(k * 4));
      exp_q.push_back(32'((k >> 3) * (k & 7)));
    end
    for (int k = 0; k < 64; k++) begin
      ea = exp_q.pop_front();
      ed = exp_q.pop_front();
      check_eq($sformatf("%s_addr%0d", tag, k), (k < wr_addr_q.size()) ? wr_addr_q[k] : 32'hFFFF_FFFF, ea);
      check_eq($sformatf("%s_data%0d", tag, k), (k < wr_data_q.size()) ? wr_data_q[k] : 32'hFFFF_FFFF, ed);
    end
  endtask

  initial begin
`ifndef TIMES_INIT_EN
    for (int i = 0; i < 64; i++) mem[i] = 32'hABCD_EFC0 | 32'((i >> 3) * (i & 7));
`else
    for (int i = 0; i < 64; i++) mem[i] = '0;
`endif
    rst = 1;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_aresetn", 32'(m_axi_aresetn), 0);
    check_eq("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check_eq("rst_ready", 32'(ready), 0);
    check_eq("rst_result", 32'(result), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_err", 32'(err), 0);

    @(negedge clk);
    rst = 0;
    #2;
    check_eq("post_rst_aresetn", 32'(m_axi_aresetn), 1);
`ifdef TIMES_INIT_EN
    check_eq("post_rst_init_done", 32'(init_done), 0);
    check_eq("post_rst_ready", 32'(ready), 0);
    check_eq("post_rst_awvalid", 32'(m_axi_awvalid), 1);
    check_eq("post_rst_wstrb", 32'(m_axi_wstrb), 32'hF);
    check_init("init1");
`else
    check_eq("post_rst_init_done", 32'(init_done), 1);
    check_eq("post_rst_ready", 32'(ready), 1);
    check_eq("post_rst_wr_outs", m_axi_awaddr | m_axi_wdata | 32'(m_axi_wstrb), 0);
`endif

    do_lookup("lk_7x7", 3'd7, 3'd7, 32'h0000_00FC, 6'd49, 3, 0);
    do_lookup("lk_0x0", 3'd0, 3'd0, 32'h0000_0000, 6'd0, 3, 0);
    do_lookup("lk_7x0", 3'd7, 3'd0, 32'h0000_00E0, 6'd0, 3, 0);
    do_lookup("lk_4x7", 3'd4, 3'd7, 32'h0000_009C, 6'd28, 3, 0);

    ar_wait = 5; r_delay = 2;
    do_lookup("lk_slow_2x6", 3'd2, 3'd6, 32'h0000_0058, 6'd12, 10, 1);
    ar_wait = 0; r_delay = 0;

    rresp_v = 2'b10;
    do_lookup("lk_err_3x5", 3'd3, 3'd5, 32'h0000_0074, 6'd15, 3, 0);
    rresp_v = 2'b00;
    check_eq("err_set", 32'(err), 1);
    do_lookup("lk_1x1", 3'd1, 3'd1, 32'h0000_0024, 6'd1, 3, 0);
    check_eq("err_sticky", 32'(err), 1);

    // Reset while a read address is outstanding.
    ar_wait = 5;
    @(negedge clk);
    a = 3'd5; b = 3'd2; req = 1;
    @(negedge clk);
    req = 0;
    #2;
    check_eq("mid_arvalid_before", 32'(m_axi_arvalid), 1);
    @(negedge clk);
    rst = 1;
    #2;
    check_eq("mid_rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check_eq("mid_rst_aresetn", 32'(m_axi_aresetn), 0);
    @(negedge clk);
    rst = 0;
    ar_wait = 0;
    #2;
    check_eq("mid_rst_err_clear", 32'(err), 0);
    check_eq("mid_rst_result", 32'(result), 0);
    check_eq("mid_rst_arvalid", 32'(m_axi_arvalid), 0);
`ifdef TIMES_INIT_EN
    check_eq("mid_rst_restart_addr", m_axi_awaddr, 0);
    check_eq("mid_rst_ready", 32'(ready), 0);
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 2000 && !hit; k++) begin
        @(negedge clk); #2;
        if (wr_cnt == 20 && m_axi_awvalid) hit = 1;
      end
      check_eq("wr20_reached", 32'(hit), 1);
    end
    @(negedge clk);
    rst = 1;
    #2;
    check_eq("wr20_rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    @(negedge clk);
    rst = 0;
    #2;
    check_eq("wr20_restart_addr", m_axi_awaddr, 0);
    check_eq("wr20_restart_awvalid", 32'(m_axi_awvalid), 1);
    check_init("init2");
    do_lookup("lk_after_init2", 3'd6, 3'd5, 32'h0000_00D4, 6'd30, 3, 0);
`else
    check_eq("mid_rst_ready", 32'(ready), 1);
    do_lookup("lk_first_after_rst", 3'd6, 3'd5, 32'h0000_00D4, 6'd30, 3, 0);
    check_eq("no_wr_activity", wr_act, 0);
    check_eq("no_aw_handshake", aw_hs_n + w_hs_n + b_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_times_ctrl.md
AXI_LITE_TIMES_CTRL -- requirements
Module: axi_lite_times_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, AXI address width.
REQ-002 Parameter: DATA_W, 32, AXI data width.
REQ-003 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a, b  in  3 each  operands
- req  in  1  lookup request
- ready  out  1  accepting req
- result  out  6  product
- valid  out  1  result strobe
- init_done  out  1  table loaded
- err  out  1  sticky response error
- m_axi_aresetn  out  1  equals ~rst
- m_axi_awaddr/awvalid  out  ADDR_W/1;  m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_W/4/1;  m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_araddr/arvalid  out  ADDR_W/1;  m_axi_arready  in  1
- m_axi_rdata  in  DATA_W;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Function
REQ-005 The address SHALL be {zeros, a, b, 2'b00}; the entry index is {a,b}, 0..63, word-aligned.
REQ-006 FSM states SHALL be INIT_WR, INIT_B, IDLE, RD_AR, RD_R.
REQ-007 INIT_WR SHALL assert awvalid and wvalid for index i, with wdata = a_i*b_i zero-extended and wstrb = 4'hF.
REQ-008 awvalid and wvalid SHALL each drop independently in the cycle after its own ready handshake; when both have completed (including same-cycle completion), the FSM SHALL go to INIT_B.
REQ-009 INIT_B SHALL hold bready=1 until bvalid. On bvalid, if i=63 the FSM SHALL go to IDLE and set init_done; otherwise it SHALL increment i and return to INIT_WR.
REQ-010 ready SHALL be 1 only in IDLE. req&&ready SHALL latch a and b and go to RD_AR; req in any other state SHALL be ignored.
REQ-011 RD_AR SHALL hold arvalid=1 with a stable araddr until arready, then go to RD_R.
REQ-012 RD_R SHALL hold rready=1. On rvalid it SHALL register result=rdata[5:0], pulse valid for exactly one cycle, and return to IDLE.
REQ-013 Lookup latency SHALL be 3 cycles from req to valid with zero-wait slaves; each slave wait cycle adds one.
REQ-014 A non-OKAY bresp or rresp SHALL set err; err SHALL clear only on rst. The result is still delivered on an rresp error.
REQ-015 result SHALL hold its value between valid pulses.
REQ-016 No valid SHALL ever be withdrawn before its ready.

Reset
REQ-017 On rst, every AXI valid and ready output SHALL be 0, and m_axi_aresetn SHALL be 0.
REQ-018 On rst, result=0, valid=0, err=0, init_done=0, and i=0.
REQ-019 After rst, the FSM SHALL be in INIT_WR (or IDLE without the macro).
REQ-020 Reset mid-transaction SHALL abandon the transaction and restart the initialisation from index 0.

Configuration
REQ-021 Macro TIMES_INIT_EN:
- Defined: the initialisation phase is as above.
- Undefined: INIT states are absent; the FSM resets to IDLE with init_done=1; awvalid, wvalid, bready, awaddr, wdata and wstrb are tied to 0.

Structure
REQ-022 Package times_ctrl_pkg SHALL hold:
- the state enum
- the AXI_OKAY=2'b00 constant
- the TABLE_DEPTH=64 constant
- an address-build function
REQ-023 Sub-module axi_lite_wr_chan SHALL hold the independent AW/W valid-drop tracking; all other logic stays flat.

Verification
REQ-024 Zero-wait slave model after reset: exactly 64 writes; write k has addr k*4 and data (k>>3)*(k&7); init_done rises after the 64th bresp.
REQ-025 Lookup a=7, b=7: araddr=0xFC, result=49, valid pulses once, 3 cycles after req.
REQ-026 arready held low 5 cycles and rvalid delayed 2 cycles: araddr stable throughout, result correct, ready=0 while busy.
REQ-027 Out-of-order ready on one init write: awready one cycle before wready, then the reverse. Each valid drops only after its own handshake, with no duplicate write.
REQ-028 rresp=2'b10 on a lookup of a=3, b=5: err=1 sticky, result=15. A later rst clears err.
REQ-029 rst asserted at write index 20: all valids 0 next cycle; initialisation restarts at addr 0. Without TIMES_INIT_EN: no AW/W activity, and the first req is served immediately.
